// File: rtl/v_pkg.sv
// ----------------------------------------------------------------------------
// v_pkg
// Shared types for the `v` list block and its update-bus arbiter.
//   id_t / cmd_t / key_t / size_t : fields of one list update
//   upd_t                         : packed update {prod_id, cmd, key, size}
//   V_UPD_ARB_N_REQ_MAX           : largest requester count v_upd_arb supports
// ----------------------------------------------------------------------------
package v_pkg;

    localparam int ID_W   = 8;
    localparam int KEY_W  = 16;
    localparam int SIZE_W = 16;

    typedef logic [ID_W-1:0]   id_t;
    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [SIZE_W-1:0] size_t;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_MOD = 2'd1,
        CMD_DEL = 2'd2,
        CMD_CLR = 2'd3
    } cmd_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

    localparam int V_UPD_ARB_N_REQ_MAX = 8;

endpackage

// File: rtl/v_upd_arb_rr.sv
// ----------------------------------------------------------------------------
// v_upd_arb_rr
// Generic N-way round-robin picker. Grants the first eligible index at or
// after the pointer (wrapping); the pointer moves to winner+1 only when the
// advance strobe is high, otherwise it holds so skipped requesters keep
// their relative priority.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   elig_i   : eligible vector
//   adv_i    : advance strobe (grant accepted this cycle)
//   gnt_o    : one-hot grant, zero when nothing is eligible
// ----------------------------------------------------------------------------
module v_upd_arb_rr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] elig_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx, win_idx;
    logic          found;

    // Scan N slots starting at the pointer; the first eligible slot wins.
    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        idx     = '0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && elig_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        if (found) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/v_upd_arb.sv
// ----------------------------------------------------------------------------
// v_upd_arb
// Shares the single update bus of `v` between N_REQ feed sources.
// Round-robin grant, stalled while `v` is busy, and a per-prod_id hazard
// window so the same product is never re-issued within HAZARD_CYCLES cycles.
// A request accepted in cycle t is presented on o_upd_*_r in cycle t+1.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_req_*           : per-requester valid + payload (prod_id/cmd/key/size)
//   o_req_rdy         : combinational one-hot grant (transfer on vld & rdy)
//   i_v_busy_r        : `v` busy, blocks all grants
//   o_upd_*_r         : registered update bus to `v`
//   o_busy_r          : requests pending, update in flight or window active
//   i_stats_clr       : (V_UPD_ARB_STATS_EN) clear stall counters
//   o_stall_cnt_r     : (V_UPD_ARB_STATS_EN) per-requester saturating
//                       16-bit count of cycles valid but not granted
//
// Build option: define V_UPD_ARB_STATS_EN to add the stall counters.
// ----------------------------------------------------------------------------
module v_upd_arb
    import v_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int HAZARD_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       i_req_vld,
    input  id_t  [N_REQ-1:0]       i_req_prod_id,
    input  cmd_t [N_REQ-1:0]       i_req_cmd,
    input  key_t [N_REQ-1:0]       i_req_key,
    input  size_t [N_REQ-1:0]      i_req_size,
    output logic [N_REQ-1:0]       o_req_rdy,
`ifdef V_UPD_ARB_STATS_EN
    input  logic                   i_stats_clr,
    output logic [N_REQ-1:0][15:0] o_stall_cnt_r,
`endif
    input  logic                   i_v_busy_r,
    output logic                   o_upd_vld_r,
    output id_t                    o_upd_prod_id_r,
    output cmd_t                   o_upd_cmd_r,
    output key_t                   o_upd_key_r,
    output size_t                  o_upd_size_r,
    output logic                   o_busy_r
);

    localparam int HW = (HAZARD_CYCLES > 0) ? HAZARD_CYCLES : 1;

    upd_t [N_REQ-1:0] req_upd;
    upd_t             win_upd;
    logic [N_REQ-1:0] hit;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic             grant;
    logic             win_any;

    upd_t upd_q, upd_d;
    logic upd_vld_q, upd_vld_d;
    logic busy_q, busy_d;

    for (genvar r = 0; r < N_REQ; r++) begin : g_pack
        assign req_upd[r] = '{prod_id: i_req_prod_id[r],
                              cmd:     i_req_cmd[r],
                              key:     i_req_key[r],
                              size:    i_req_size[r]};
    end

    // Reset also masks eligibility so no request is acked while rst is high.
    assign elig  = i_req_vld & ~hit & {N_REQ{~i_v_busy_r & ~rst}};
    assign grant = |gnt;

    v_upd_arb_rr #(
        .N (N_REQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .elig_i (elig),
        .adv_i  (grant),
        .gnt_o  (gnt)
    );

    assign o_req_rdy = gnt;

    always_comb begin
        win_upd = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (gnt[r]) begin
                win_upd = req_upd[r];
            end
        end
    end

    // Hazard window: entry 0 takes this cycle's issue, older entries age by
    // one every cycle regardless of stalls. An id accepted at t is visible
    // in cycles t+1..t+HAZARD_CYCLES and free again at t+HAZARD_CYCLES+1.
    if (HAZARD_CYCLES > 0) begin : g_haz
        logic [HW-1:0] win_vld_q, win_vld_d;
        id_t  [HW-1:0] win_id_q,  win_id_d;

        always_comb begin
            win_vld_d    = win_vld_q;
            win_id_d     = win_id_q;
            win_vld_d[0] = grant;
            win_id_d[0]  = win_upd.prod_id;
            for (int e = 1; e < HW; e++) begin
                win_vld_d[e] = win_vld_q[e-1];
                win_id_d[e]  = win_id_q[e-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                win_vld_q <= '0;
                win_id_q  <= '0;
            end else begin
                win_vld_q <= win_vld_d;
                win_id_q  <= win_id_d;
            end
        end

        always_comb begin
            hit = '0;
            for (int r = 0; r < N_REQ; r++) begin
                for (int e = 0; e < HW; e++) begin
                    if (win_vld_q[e] && (win_id_q[e] == req_upd[r].prod_id)) begin
                        hit[r] = 1'b1;
                    end
                end
            end
        end

        assign win_any = |win_vld_q;
    end else begin : g_no_haz
        assign hit     = '0;
        assign win_any = 1'b0;
    end

    // Output bus: valid pulses for one cycle per grant; payload holds
    // between grants.
    always_comb begin
        upd_vld_d = grant;
        upd_d     = grant ? win_upd : upd_q;
        busy_d    = (|i_req_vld) | upd_vld_q | win_any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_vld_q <= 1'b0;
            upd_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            upd_vld_q <= upd_vld_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
        end
    end

    assign o_upd_vld_r     = upd_vld_q;
    assign o_upd_prod_id_r = upd_q.prod_id;
    assign o_upd_cmd_r     = upd_q.cmd;
    assign o_upd_key_r     = upd_q.key;
    assign o_upd_size_r    = upd_q.size;
    assign o_busy_r        = busy_q;

`ifdef V_UPD_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] stall_cnt_q, stall_cnt_d;

    // Clear wins over increment; counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int r = 0; r < N_REQ; r++) begin
            if (i_stats_clr) begin
                stall_cnt_d[r] = '0;
            end else if (i_req_vld[r] && !gnt[r] && (stall_cnt_q[r] != 16'hFFFF)) begin
                stall_cnt_d[r] = stall_cnt_q[r] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt_r = stall_cnt_q;
`endif

endmodule

// File: tb/tb_v_upd_arb.sv
// ----------------------------------------------------------------------------
// tb_v_upd_arb
// Directed bench for v_upd_arb (N_REQ=4, HAZARD_CYCLES=3). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// Define V_UPD_ARB_STATS_EN to also exercise the stall counters.
// ----------------------------------------------------------------------------
module tb_v_upd_arb;
    import v_pkg::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     vld;
    id_t  [N-1:0]     pid;
    cmd_t [N-1:0]     cmd;
    key_t [N-1:0]     key;
    size_t [N-1:0]    size;
    logic [N-1:0]     rdy;
    logic             v_busy;
    logic             upd_vld;
    id_t              upd_pid;
    cmd_t             upd_cmd;
    key_t             upd_key;
    size_t            upd_size;
    logic             busy;
`ifdef V_UPD_ARB_STATS_EN
    logic             stats_clr;
    logic [N-1:0][15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    v_upd_arb #(
        .N_REQ         (N),
        .HAZARD_CYCLES (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_vld       (vld),
        .i_req_prod_id   (pid),
        .i_req_cmd       (cmd),
        .i_req_key       (key),
        .i_req_size      (size),
        .o_req_rdy       (rdy),
`ifdef V_UPD_ARB_STATS_EN
        .i_stats_clr     (stats_clr),
        .o_stall_cnt_r   (stall_cnt),
`endif
        .i_v_busy_r      (v_busy),
        .o_upd_vld_r     (upd_vld),
        .o_upd_prod_id_r (upd_pid),
        .o_upd_cmd_r     (upd_cmd),
        .o_upd_key_r     (upd_key),
        .o_upd_size_r    (upd_size),
        .o_busy_r        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench at the start of a cycle with rst low and pointer 0.
    task automatic do_reset();
        cyc();
        rst    = 1'b1;
        vld    = '0;
        v_busy = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int gcnt [N];

        rst    = 1'b1;
        vld    = 4'hF;
        v_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            pid[i]  = id_t'(i + 1);
            cmd[i]  = cmd_t'(i);
            key[i]  = key_t'(16'h100 + i);
            size[i] = size_t'(3 * i);
        end
`ifdef V_UPD_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // ---- reset state ----
        mid();
        check("rst_rdy", 32'(rdy), 32'h0);
        cyc();
        mid();
        check("rst_upd_vld", 32'(upd_vld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pid", 32'(upd_pid), 32'h0);
        check("rst_key", 32'(upd_key), 32'h0);
        cyc();
        rst = 1'b0;
        vld = '0;
        mid();
        check("idle_busy", 32'(busy), 32'h0);

        // ---- single requester 0, prod_id 5 ----
        cyc();
        vld    = 4'b0001;
        pid[0] = 8'd5;
        mid();
        check("single_rdy", 32'(rdy), 32'h1);
        cyc();
        vld = '0;
        mid();
        check("single_upd_vld", 32'(upd_vld), 32'h1);
        check("single_pid", 32'(upd_pid), 32'h5);
        check("single_busy_t1", 32'(busy), 32'h1);
        cyc();
        mid();
        check("single_one_shot", 32'(upd_vld), 32'h0);
        cyc();
        mid();
        cyc();
        mid();
        check("single_busy_t4", 32'(busy), 32'h1);
        cyc();
        mid();
        check("single_busy_t5", 32'(busy), 32'h0);

        // ---- all four requesters, distinct ids 1..4 ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            pid[i] = id_t'(i + 1);
            gcnt[i] = 0;
        end
        vld = 4'hF;
        for (int k = 0; k < 8; k++) begin
            mid();
            check("rr_rdy", 32'(rdy), 32'(1) << (k % 4));
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) gcnt[i]++;
            end
            if (k >= 1) begin
                check("rr_upd_vld", 32'(upd_vld), 32'h1);
                check("rr_pid", 32'(upd_pid), 32'((k - 1) % 4 + 1));
                check("rr_key", 32'(upd_key), 32'(16'h100 + (k - 1) % 4));
                check("rr_size", 32'(upd_size), 32'(3 * ((k - 1) % 4)));
                check("rr_cmd", 32'(upd_cmd), 32'((k - 1) % 4));
            end
            cyc();
        end
        for (int i = 0; i < N; i++) begin
            check("rr_fair", 32'(gcnt[i]), 32'd2);
        end

        // ---- hazard: requesters 0 and 1 both prod_id 7 ----
        do_reset();
        pid[0] = 8'd7;
        pid[1] = 8'd7;
        vld    = 4'b0011;
        mid();
        check("haz_rdy_t0", 32'(rdy), 32'h1);
        cyc();
        vld = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            mid();
            check("haz_blocked", 32'(rdy), 32'h0);
            check("haz_upd_vld", 32'(upd_vld), (k == 1) ? 32'h1 : 32'h0);
            if (k == 1) check("haz_pid_t1", 32'(upd_pid), 32'h7);
            cyc();
        end
        mid();
        check("haz_rdy_t4", 32'(rdy), 32'h2);
        check("haz_quiet_t4", 32'(upd_vld), 32'h0);
        cyc();
        vld = '0;
        mid();
        check("haz_upd_t5", 32'(upd_vld), 32'h1);
        check("haz_pid_t5", 32'(upd_pid), 32'h7);

        // ---- v busy stall with requester 2 valid ----
        do_reset();
        pid[2] = 8'd9;
        vld    = 4'b0100;
        v_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            check("stall_rdy", 32'(rdy), 32'h0);
            cyc();
        end
        v_busy = 1'b0;
        mid();
        check("stall_release_rdy", 32'(rdy), 32'h4);
        check("stall_busy", 32'(busy), 32'h1);
        cyc();
        vld = '0;
        mid();
        check("stall_upd_vld", 32'(upd_vld), 32'h1);
        check("stall_pid", 32'(upd_pid), 32'h9);

        // ---- reset mid-operation ----
        do_reset();
        for (int i = 0; i < N; i++) pid[i] = id_t'(i + 1);
        vld = 4'hF;
        mid();
        check("mrst_rdy0", 32'(rdy), 32'h1);
        cyc();
        mid();
        check("mrst_rdy1", 32'(rdy), 32'h2);
        cyc();
        rst = 1'b1;
        mid();
        check("mrst_no_ack", 32'(rdy), 32'h0);
        check("mrst_inflight", 32'(upd_vld), 32'h1);
        cyc();
        mid();
        check("mrst_upd_drop", 32'(upd_vld), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_pid", 32'(upd_pid), 32'h0);
        check("mrst_no_ack2", 32'(rdy), 32'h0);
        cyc();
        rst = 1'b0;
        mid();
        check("mrst_restart", 32'(rdy), 32'h1);
        cyc();
        vld = '0;

`ifdef V_UPD_ARB_STATS_EN
        // ---- stall counter saturation and clear ----
        do_reset();
        v_busy = 1'b1;
        vld    = 4'b1000;
        mid();
        check("stats_start", 32'(stall_cnt[3]), 32'h0);
        repeat (70000) cyc();
        mid();
        check("stats_sat", 32'(stall_cnt[3]), 32'hFFFF);
        check("stats_idle_req", 32'(stall_cnt[0]), 32'h0);
        cyc();
        stats_clr = 1'b1;
        mid();
        check("stats_hold", 32'(stall_cnt[3]), 32'hFFFF);
        cyc();
        stats_clr = 1'b0;
        mid();
        check("stats_clr", 32'(stall_cnt[3]), 32'h0);
        cyc();
        vld    = '0;
        v_busy = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/v_upd_arb.md
Name: v_upd_arb

Overview:
- Shares the single list update bus of `v` (i_upd_*) between N_REQ independent feed sources.
- Round-robin arbitration with valid/ready handshakes per requester.
- Stalls all grants while `v` reports busy.
- Enforces a per-product hazard window: two updates to the same prod_id are never issued within HAZARD_CYCLES cycles of each other.
- Sits directly in front of `v`; the output bus is registered.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HAZARD_CYCLES, 3, cycles after issue during which the same prod_id is blocked (0 = no hazard check).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_req_vld  in  N_REQ  per-requester update valid
- i_req_prod_id  in  N_REQ x v_pkg::id_t  product id
- i_req_cmd  in  N_REQ x v_pkg::cmd_t  command
- i_req_key  in  N_REQ x v_pkg::key_t  key
- i_req_size  in  N_REQ x v_pkg::size_t  size
- o_req_rdy  out  N_REQ  combinational grant; transfer when vld & rdy
- i_v_busy_r  in  1  `v` o_busy_r
- o_upd_vld_r  out  1  to `v` i_upd_vld
- o_upd_prod_id_r  out  v_pkg::id_t  to i_upd_prod_id
- o_upd_cmd_r  out  v_pkg::cmd_t  to i_upd_cmd
- o_upd_key_r  out  v_pkg::key_t  to i_upd_key
- o_upd_size_r  out  v_pkg::size_t  to i_upd_size
- o_busy_r  out  1  arbiter has in-flight or blocked work

Behaviour:
- Reset: all o_upd_*_r = 0, o_busy_r = 0, RR pointer = 0, hazard window cleared, o_req_rdy = 0 during rst.
- Eligible[i] = i_req_vld[i] & !i_v_busy_r & !hit(i_req_prod_id[i]).
  - hit() compares against all valid entries of the hazard window.
- Grant: at most one per cycle. The winner is the first eligible index at or after the RR pointer, modulo N_REQ. o_req_rdy is one-hot or zero.
- Pointer: updates to winner+1 mod N_REQ on grant only; otherwise it holds.
  - A hazard-blocked requester therefore keeps its relative priority.
- Latency: request accepted in cycle t appears on o_upd_*_r in cycle t+1, for exactly one cycle. o_upd_vld_r = 0 in cycles with no grant; payload registers load only on grant.
- Hazard window:
  - Shift register of HAZARD_CYCLES entries {vld, prod_id}.
  - Entry 0 is loaded with {grant, winner prod_id} each cycle; entries shift every cycle, including stalls.
  - Net effect: same prod_id is re-issuable no earlier than t+HAZARD_CYCLES+1 after acceptance at t.
  - HAZARD_CYCLES=0: no window, hit() = 0.
- Requester contract: payload held stable while vld & !rdy. Violations are unchecked; the value sampled on the grant cycle wins.
- Busy: i_v_busy_r = 1 blocks all grants; window entries still age.
- Simultaneous requests with equal prod_id: only the RR winner issues; the other is blocked by hit for HAZARD_CYCLES cycles.
- o_busy_r (registered) = |i_req_vld | o_upd_vld_r | any window entry valid.
- Reset mid-operation: pending requests are not acked; an issued update already on o_upd_vld_r is dropped next cycle (not replayed); window is flushed.

Optional Feature:
- V_UPD_ARB_STATS_EN
- Defined: adds output o_stall_cnt_r [N_REQ x 16].
  - Per-requester saturating counter (stops at 16'hFFFF).
  - Increments each cycle i_req_vld[i] & !o_req_rdy[i].
  - Cleared on rst and on input i_stats_clr (1-bit, synchronous).
- Undefined: ports and counters absent; no other behavioural change.

Decomposition:
- v_pkg additions:
  - upd_t packed struct {prod_id, cmd, key, size}; requester and output buses are carried internally as upd_t.
  - Constant V_UPD_ARB_N_REQ_MAX = 8.
- One sub-module: v_upd_arb_rr.
  - Generic N-way round-robin picker.
  - Inputs: eligible vector, advance strobe. Output: one-hot grant.
  - Owns the pointer register.
  - Hazard window and payload mux stay in v_upd_arb.

Test Plan:
- Single requester 0 issues prod_id=5 at cycle 10:
  - o_req_rdy[0]=1 at 10.
  - o_upd_vld_r=1 with prod_id 5 at 11 only.
  - o_busy_r clears after window drains, at cycle 15 with HAZARD_CYCLES=3.
- All 4 requesters valid, distinct ids 1..4, continuously:
  - Grants 0,1,2,3,0,... one per cycle.
  - o_upd_vld_r held high.
  - Each requester gets exactly 1 grant per 4 cycles.
- Requesters 0 and 1 both prod_id=7, HAZARD_CYCLES=3:
  - Req0 granted at t.
  - Req1 first granted at t+4.
  - No other o_upd_vld_r with id 7 in between.
- i_v_busy_r=1 for cycles 20..24 with req 2 valid:
  - o_req_rdy all 0 during 20..24.
  - Req 2 granted at 25, issued at 26.
- rst asserted at cycle 30 while 3 requests pending and o_upd_vld_r=1:
  - Cycle 31: all outputs 0, window clear, no acks.
  - After rst deasserts, grant order restarts at requester 0.
- STATS build: req 3 blocked by busy for 70000 cycles:
  - o_stall_cnt_r[3] saturates at 0xFFFF.
  - i_stats_clr returns it to 0 the next cycle.
